// File: rtl/coproc_cmd_seq_if.sv
// Command-side and coprocessor-side handshake bundle for coproc_cmd_seq.
// master: the sequencer itself; slave: the command source / coprocessor environment.
interface coproc_cmd_seq_if #(
    parameter int FUNC_W = 3,
    parameter int IDX_W  = 1
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [FUNC_W-1:0] cmd_func;
    logic              cmd_gray;
    logic [IDX_W-1:0]  cmd_idx;
    logic              cp_start;
    logic [FUNC_W-1:0] cp_func;
    logic              cp_gray;
    logic [IDX_W-1:0]  cp_img_idx;
    logic              cp_rdy;
    logic              cp_done;

    modport master (
        input  cmd_valid, cmd_func, cmd_gray, cmd_idx, cp_rdy, cp_done,
        output cmd_ready, cp_start, cp_func, cp_gray, cp_img_idx
    );

    modport slave (
        output cmd_valid, cmd_func, cmd_gray, cmd_idx, cp_rdy, cp_done,
        input  cmd_ready, cp_start, cp_func, cp_gray, cp_img_idx
    );
endinterface

// File: rtl/coproc_cmd_seq.sv
// FIFO-buffered command sequencer issuing one start/done handshake per command to the image coprocessor.
// Optional RUN watchdog is enabled by defining COPROC_CMD_SEQ_TIMEOUT_EN.
module coproc_cmd_seq #(
    parameter int DEPTH   = 4,
    parameter int FUNC_W  = 3,
    parameter int IDX_W   = 1,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 100000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    coproc_cmd_seq_if.master       bus,
    output logic                   busy,
    output logic                   cmpl_valid,
    output logic [CNT_W-1:0]       cmpl_count,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic                   err_timeout,
    input  logic                   clr_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int EW = FUNC_W + 1 + IDX_W;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_RDY = 2'd1,
        ST_RUN      = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic [EW-1:0]     fifo_mem_r [DEPTH];
    logic [PW-1:0]     wr_ptr_r;
    logic [PW-1:0]     rd_ptr_r;
    logic              full_s;
    logic              empty_s;
    logic              push_s;
    logic              pop_s;
    logic [EW-1:0]     head_s;
    logic              start_set_s;
    logic              cmpl_set_s;
    logic              end_cmd_s;
    logic              wd_hit_s;
    logic              wd_expire_s;
    logic              cp_start_r;
    logic [FUNC_W-1:0] cp_func_r;
    logic              cp_gray_r;
    logic [IDX_W-1:0]  cp_img_idx_r;
    logic              cmpl_valid_r;
    logic [CNT_W-1:0]  cmpl_count_r;

    // The extra pointer bit distinguishes full from empty when the slot indices match.
    assign empty_s = (wr_ptr_r == rd_ptr_r);
    assign full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign head_s  = fifo_mem_r[rd_ptr_r[AW-1:0]];
    // A push into a full FIFO still lands when the head leaves on the same edge.
    assign push_s  = bus.cmd_valid && (!full_s || pop_s);

    // Command FIFO storage and circular pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_mem_r[i] <= '0;
            end
        end else begin
            if (push_s) begin
                fifo_mem_r[wr_ptr_r[AW-1:0]] <= {bus.cmd_func, bus.cmd_gray, bus.cmd_idx};
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
        end
    end

`ifdef COPROC_CMD_SEQ_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);

    logic [WD_W-1:0] wd_cnt_r;
    logic            err_r;

    assign wd_hit_s    = (wd_cnt_r == WD_W'(TIMEOUT - 1));
    assign err_timeout = err_r;

    // Watchdog counts cycles spent in RUN, restarting with every start pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt_r <= '0;
        end else if (start_set_s) begin
            wd_cnt_r <= '0;
        end else if (state_r == ST_RUN) begin
            wd_cnt_r <= wd_cnt_r + WD_W'(1);
        end
    end

    // Sticky timeout flag; a fresh expiry outranks a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_r <= 1'b0;
        end else if (wd_expire_s) begin
            err_r <= 1'b1;
        end else if (clr_err) begin
            err_r <= 1'b0;
        end
    end
`else
    logic unused_wd_s;

    assign wd_hit_s    = 1'b0;
    assign unused_wd_s = clr_err | wd_expire_s;
    assign err_timeout = 1'b0;
`endif

    // Sequencer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and per-cycle control: pops, start request, completion and expiry.
    always_comb begin
        state_s     = state_r;
        pop_s       = 1'b0;
        start_set_s = 1'b0;
        cmpl_set_s  = 1'b0;
        end_cmd_s   = 1'b0;
        wd_expire_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!empty_s) begin
                    pop_s   = 1'b1;
                    state_s = ST_WAIT_RDY;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT_RDY: begin
                if (bus.cp_rdy) begin
                    start_set_s = 1'b1;
                    state_s     = ST_RUN;
                end else begin
                    state_s = ST_WAIT_RDY;
                end
            end
            ST_RUN: begin
                // cp_done on the expiry cycle counts as a normal completion.
                if (bus.cp_done) begin
                    cmpl_set_s = 1'b1;
                    end_cmd_s  = 1'b1;
                end else if (wd_hit_s) begin
                    wd_expire_s = 1'b1;
                    end_cmd_s   = 1'b1;
                end else begin
                    end_cmd_s = 1'b0;
                end
                if (end_cmd_s) begin
                    if (!empty_s) begin
                        pop_s   = 1'b1;
                        state_s = ST_WAIT_RDY;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else begin
                    state_s = ST_RUN;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Registered coprocessor fields, start pulse and completion reporting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cp_start_r   <= 1'b0;
            cp_func_r    <= '0;
            cp_gray_r    <= 1'b0;
            cp_img_idx_r <= '0;
            cmpl_valid_r <= 1'b0;
            cmpl_count_r <= '0;
        end else begin
            cp_start_r   <= start_set_s;
            cmpl_valid_r <= cmpl_set_s;
            if (pop_s) begin
                {cp_func_r, cp_gray_r, cp_img_idx_r} <= head_s;
            end
            if (cmpl_set_s) begin
                cmpl_count_r <= cmpl_count_r + CNT_W'(1);
            end
        end
    end

    assign bus.cmd_ready  = !full_s;
    assign bus.cp_start   = cp_start_r;
    assign bus.cp_func    = cp_func_r;
    assign bus.cp_gray    = cp_gray_r;
    assign bus.cp_img_idx = cp_img_idx_r;
    assign cmpl_valid     = cmpl_valid_r;
    assign cmpl_count     = cmpl_count_r;
    assign fifo_level     = wr_ptr_r - rd_ptr_r;
    assign busy           = (state_r != ST_IDLE) || !empty_s;
endmodule

// File: tb/tb_coproc_cmd_seq.sv
// Directed plus randomized bench for coproc_cmd_seq against a queue-based command-flow model.
module tb_coproc_cmd_seq;
    localparam int DEPTH = 4;
`ifdef COPROC_CMD_SEQ_TIMEOUT_EN
    localparam bit TIMEOUT_ON = 1'b1;
    localparam int TB_TIMEOUT = 100;
    localparam int DONE_WAIT  = 50;
`else
    localparam bit TIMEOUT_ON = 1'b0;
    localparam int TB_TIMEOUT = 100000;
    localparam int DONE_WAIT  = 70000;
`endif

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b1;
    logic        clr_err = 1'b0;
    logic        busy;
    logic        cmpl_valid;
    logic [15:0] cmpl_count;
    logic [2:0]  fifo_level;
    logic        err_timeout;

    coproc_cmd_seq_if #(.FUNC_W(3), .IDX_W(1)) bus ();

    coproc_cmd_seq #(
        .DEPTH(DEPTH), .FUNC_W(3), .IDX_W(1), .CNT_W(16), .TIMEOUT(TB_TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.master), .busy(busy), .cmpl_valid(cmpl_valid),
        .cmpl_count(cmpl_count), .fifo_level(fifo_level), .err_timeout(err_timeout), .clr_err(clr_err)
    );

    always #5 clk = ~clk;

    int          n_cmp  = 0;
    int          n_fail = 0;
    // Model: pending commands, the command held by the coprocessor port and whether it has been started.
    logic [4:0]  mq[$];
    logic [4:0]  held;
    bit          holding, launched, m_start, m_cmpl, m_err;
    logic [15:0] m_count;
    int          run_cycles;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        held = 5'd0; holding = 1'b0; launched = 1'b0; m_start = 1'b0; m_cmpl = 1'b0;
        m_err = 1'b0; m_count = 16'd0; run_cycles = 0;
    endtask

    // One clock edge of command flow, driven only by the inputs presented at that edge.
    task automatic model_edge();
        bit fin, expire, pop, push;
        fin = 1'b0; expire = 1'b0; m_start = 1'b0; m_cmpl = 1'b0;
        if (holding && launched) begin
            if (bus.cp_done) begin
                fin = 1'b1; m_cmpl = 1'b1; m_count = m_count + 16'd1;
            end else if (TIMEOUT_ON && run_cycles == TB_TIMEOUT - 1) begin
                fin = 1'b1; expire = 1'b1;
            end else begin
                run_cycles++;
            end
        end
        if (expire) m_err = 1'b1;
        else if (TIMEOUT_ON && clr_err) m_err = 1'b0;
        if (holding && !launched && bus.cp_rdy) begin
            m_start = 1'b1; launched = 1'b1; run_cycles = 0;
        end
        if (fin) begin
            holding = 1'b0; launched = 1'b0;
        end
        pop  = !holding && (mq.size() > 0);
        push = bus.cmd_valid && ((mq.size() < DEPTH) || pop);
        if (pop) begin
            held = mq.pop_front(); holding = 1'b1; launched = 1'b0;
        end
        if (push) mq.push_back({bus.cmd_func, bus.cmd_gray, bus.cmd_idx});
    endtask

    task automatic check_all();
        chk("cp_start",    32'(bus.cp_start),   32'(m_start));
        chk("cp_func",     32'(bus.cp_func),    32'(held[4:2]));
        chk("cp_gray",     32'(bus.cp_gray),    32'(held[1]));
        chk("cp_img_idx",  32'(bus.cp_img_idx), 32'(held[0]));
        chk("cmpl_valid",  32'(cmpl_valid),     32'(m_cmpl));
        chk("cmpl_count",  32'(cmpl_count),     32'(m_count));
        chk("fifo_level",  32'(fifo_level),     32'(mq.size()));
        chk("busy",        32'(busy),           32'(holding || (mq.size() > 0)));
        chk("cmd_ready",   32'(bus.cmd_ready),  32'(mq.size() < DEPTH));
        chk("err_timeout", 32'(err_timeout),    32'(m_err));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_clear();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic push_cmd(input logic [2:0] f, input logic g, input logic i);
        bus.cmd_valid = 1'b1; bus.cmd_func = f; bus.cmd_gray = g; bus.cmd_idx = i;
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic pulse_done();
        bus.cp_done = 1'b1;
        tick();
        bus.cp_done = 1'b0;
    endtask

    initial begin
        bus.cmd_valid = 1'b0; bus.cmd_func = 3'd0; bus.cmd_gray = 1'b0; bus.cmd_idx = 1'b0;
        bus.cp_rdy = 1'b0; bus.cp_done = 1'b0;
        model_clear();
        apply_reset();

        // Single command, long coprocessor run.
        bus.cp_rdy = 1'b1;
        push_cmd(3'b111, 1'b0, 1'b0);
        tick();
        chk("t1_no_start_e1", 32'(bus.cp_start), 32'd0);
        tick();
        chk("t1_start_e2", 32'(bus.cp_start), 32'd1);
        tick();
        chk("t1_start_one_cycle", 32'(bus.cp_start), 32'd0);
        chk("t1_func_held", 32'(bus.cp_func), 32'd7);
        repeat (DONE_WAIT - 3) tick();
        pulse_done();
        chk("t1_cmpl_valid", 32'(cmpl_valid), 32'd1);
        chk("t1_count", 32'(cmpl_count), 32'd1);

        // Coprocessor not ready for 50 cycles.
        bus.cp_rdy = 1'b0;
        push_cmd(3'b010, 1'b1, 1'b1);
        repeat (50) tick();
        chk("t3_no_start", 32'(bus.cp_start), 32'd0);
        bus.cp_rdy = 1'b1;
        tick();
        chk("t3_start_after_rdy", 32'(bus.cp_start), 32'd1);
        tick();
        pulse_done();
        chk("t3_count", 32'(cmpl_count), 32'd2);

        // Spurious done pulses in IDLE and WAIT_RDY.
        bus.cp_done = 1'b1;
        tick(); tick();
        bus.cp_done = 1'b0;
        chk("t4_idle_no_cmpl", 32'(cmpl_valid), 32'd0);
        bus.cp_rdy = 1'b0;
        push_cmd(3'b101, 1'b0, 1'b1);
        tick();
        bus.cp_done = 1'b1;
        tick(); tick();
        bus.cp_done = 1'b0;
        chk("t4_wait_no_cmpl", 32'(cmpl_valid), 32'd0);
        chk("t4_count_same", 32'(cmpl_count), 32'd2);
        bus.cp_rdy = 1'b1;
        tick(); tick();
        pulse_done();
        chk("t4_count", 32'(cmpl_count), 32'd3);

        // Fill the FIFO behind a running command, then drain back-to-back.
        push_cmd(3'b001, 1'b0, 1'b0);
        tick(); tick();
        push_cmd(3'b011, 1'b1, 1'b0);
        push_cmd(3'b100, 1'b0, 1'b1);
        push_cmd(3'b110, 1'b1, 1'b1);
        push_cmd(3'b000, 1'b0, 1'b0);
        chk("t2_level_full", 32'(fifo_level), 32'd4);
        chk("t2_ready_low", 32'(bus.cmd_ready), 32'd0);
        push_cmd(3'b111, 1'b1, 1'b1);
        chk("t2_fifth_ignored", 32'(fifo_level), 32'd4);
        for (int k = 0; k < 5; k++) begin
            tick(); tick();
            pulse_done();
        end
        chk("t2_count", 32'(cmpl_count), 32'd8);
        chk("t2_busy_low", 32'(busy), 32'd0);

`ifdef COPROC_CMD_SEQ_TIMEOUT_EN
        // Watchdog expiry, next command issues, flag cleared.
        push_cmd(3'b101, 1'b1, 1'b1);
        push_cmd(3'b010, 1'b0, 1'b0);
        repeat (110) tick();
        chk("t5_err_set", 32'(err_timeout), 32'd1);
        chk("t5_next_issued", 32'(bus.cp_func), 32'd2);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("t5_err_clear", 32'(err_timeout), 32'd0);
        pulse_done();
        chk("t5_count", 32'(cmpl_count), 32'd9);
        tick();
`endif

        // Reset while running with two commands queued.
        push_cmd(3'b001, 1'b0, 1'b1);
        tick(); tick(); tick();
        push_cmd(3'b100, 1'b1, 1'b0);
        push_cmd(3'b110, 1'b0, 1'b1);
        chk("t6_level_before", 32'(fifo_level), 32'd2);
        apply_reset();
        repeat (10) tick();
        chk("t6_level_after", 32'(fifo_level), 32'd0);
        chk("t6_no_start", 32'(bus.cp_start), 32'd0);

        // Randomized traffic.
        for (int k = 0; k < 2000; k++) begin
            bus.cmd_valid = ($urandom_range(0, 2) == 0);
            bus.cmd_func  = 3'($urandom_range(0, 7));
            bus.cmd_gray  = 1'($urandom_range(0, 1));
            bus.cmd_idx   = 1'($urandom_range(0, 1));
            bus.cp_rdy    = ($urandom_range(0, 1) == 1);
            bus.cp_done   = ($urandom_range(0, 4) == 0);
            clr_err       = ($urandom_range(0, 49) == 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
